mxv_result_collector: RTL and testbench

- Downstream stage of the MxV operation counter.
- Captures one dot-product result per cycle while the counter asserts result_push, and stores the row results in a small register buffer.
- When the counter signals endop, streams the stored results out as bytes (MSB byte first) over a valid/ready interface toward the UART TX path.
- Pulses done when the last byte has been accepted.

---
 rtl/mxv_result_collector.sv | 145 ++++++++++++++
 tb/tb_mxv_result_collector.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mxv_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : mxv_result_collector
// Brief    : Buffers MxV row results and streams them out MSB byte first
//            over a valid/ready byte interface.
// Revision : 1.0 - initial release
// ============================================================================
module mxv_result_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_ROWS   = 8,
    parameter int PTR_W      = $clog2(MAX_ROWS) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            matrix_size,
    input  logic                  result_push,
    input  logic [DATA_WIDTH-1:0] result_data,
    input  logic                  endop,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int c_BYTES  = DATA_WIDTH / 8;
    localparam int c_BIDX_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam int c_ROW_W  = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
    localparam logic [PTR_W-1:0]    c_MAX_PTR   = PTR_W'(MAX_ROWS);
    localparam logic [7:0]          c_MAX_SIZE  = 8'(MAX_ROWS);
    localparam logic [c_BIDX_W-1:0] c_LAST_BYTE = c_BIDX_W'(c_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_SEND    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_buf [MAX_ROWS];
    logic [PTR_W-1:0]      r_size;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_row;
    logic [c_BIDX_W-1:0]   r_byte_idx;

    logic                  w_accept_start;
    logic                  w_collect;
    logic                  w_capture;
    logic                  w_drop;
    logic [PTR_W-1:0]      w_wr_ptr_nxt;
    logic [PTR_W-1:0]      w_size_clamped;
    logic                  w_xfer;
    logic                  w_last;
    logic [c_BIDX_W-1:0]   w_nxt_idx;
    logic [PTR_W-1:0]      w_nxt_row;
    logic [DATA_WIDTH-1:0] w_nxt_word;
    logic [DATA_WIDTH-1:0] w_nxt_shifted;
    logic [DATA_WIDTH-1:0] w_first_word;

    assign w_accept_start = (r_state == S_IDLE) && start;
    assign w_collect      = (r_state == S_COLLECT);
    assign w_capture      = w_collect && result_push && (r_wr_ptr < r_size);
    assign w_drop         = w_collect && result_push && !(r_wr_ptr < r_size);
    assign w_wr_ptr_nxt   = r_wr_ptr + PTR_W'(w_capture);
    assign w_size_clamped = (matrix_size > c_MAX_SIZE) ? c_MAX_PTR : matrix_size[PTR_W-1:0];

    assign w_xfer = (r_state == S_SEND) && out_valid && out_ready;
    assign w_last = ((r_rd_row + PTR_W'(1)) == r_wr_ptr) && (r_byte_idx == c_LAST_BYTE);

    assign w_nxt_idx     = (r_byte_idx == c_LAST_BYTE) ? '0 : r_byte_idx + c_BIDX_W'(1);
    assign w_nxt_row     = (r_byte_idx == c_LAST_BYTE) ? r_rd_row + PTR_W'(1) : r_rd_row;
    assign w_nxt_word    = r_buf[w_nxt_row[c_ROW_W-1:0]];
    assign w_nxt_shifted = w_nxt_word << {w_nxt_idx, 3'b000};

    // Row 0 may be written on the very edge that enters SEND, so bypass it.
    assign w_first_word = ((r_wr_ptr == '0) && w_capture) ? result_data : r_buf[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_COLLECT;
            S_COLLECT: if (endop) w_state_nxt = (w_wr_ptr_nxt != '0) ? S_SEND : S_DONE;
            S_SEND:    if (w_xfer && w_last) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_size     <= '0;
            r_wr_ptr   <= '0;
            r_rd_row   <= '0;
            r_byte_idx <= '0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            busy <= (w_state_nxt == S_COLLECT) || (w_state_nxt == S_SEND);
            done <= (w_state_nxt == S_DONE);
            if (w_accept_start) begin
                r_size     <= w_size_clamped;
                r_wr_ptr   <= '0;
                r_rd_row   <= '0;
                r_byte_idx <= '0;
                overflow   <= 1'b0;
            end
            if (w_capture) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_drop)    overflow <= 1'b1;
            if (w_collect && (w_state_nxt == S_SEND)) begin
                out_valid <= 1'b1;
                out_data  <= w_first_word[DATA_WIDTH-1 -: 8];
            end
            if (w_xfer) begin
                if (w_last) begin
                    out_valid <= 1'b0;
                end else begin
                    r_rd_row   <= w_nxt_row;
                    r_byte_idx <= w_nxt_idx;
                    out_data   <= w_nxt_shifted[DATA_WIDTH-1 -: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) r_buf[r_wr_ptr[c_ROW_W-1:0]] <= result_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_mxv_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_mxv_result_collector
// Brief    : Self-checking bench; expected byte stream built from the pushed
//            words with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mxv_result_collector;
    localparam int DW    = 16;
    localparam int MAXR  = 8;
    localparam int BYTES = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    matrix_size = 8'd0;
    logic          result_push = 1'b0;
    logic [DW-1:0] result_data = '0;
    logic          endop = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          busy;
    logic          done;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] words[$];
    logic [7:0]    exp_q[$];

    always #5 clk = ~clk;

    mxv_result_collector #(.DATA_WIDTH(DW), .MAX_ROWS(MAXR)) dut (
        .clk(clk), .reset(reset), .start(start), .matrix_size(matrix_size),
        .result_push(result_push), .result_data(result_data), .endop(endop),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rmode: 0 ready held high, 1 ready toggling, 2 ready random.
    // abort_after > 0 applies reset once that many bytes have been accepted.
    task automatic run_op(input logic [7:0] size, input bit simul, input int rmode,
                          input bit gaps, input int abort_after);
        int cap, n, cyc, last_cyc, nx;
        bit got_done, prev_stall, tog;
        logic [7:0] prev_data, b;
        logic [DW-1:0] w;
        cap = (size > MAXR) ? MAXR : int'(size);
        n = words.size();
        exp_q.delete();
        for (int i = 0; i < n && i < cap; i++) begin
            w = words[i];
            for (int k = BYTES - 1; k >= 0; k--) begin
                b = w[8*k +: 8];
                exp_q.push_back(b);
            end
        end

        start = 1'b1; matrix_size = size;
        tick();
        start = 1'b0;
        @(negedge clk);
        check_val("busy_after_start", busy, 1);
        check_val("ovf_cleared", overflow, 0);

        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                tick();
                result_push = 1'b0; endop = 1'b0;
            end
            tick();
            result_push = 1'b1; result_data = words[i];
            endop = simul && (i == n - 1);
        end
        if (!simul || n == 0) begin
            tick();
            result_push = 1'b0; endop = 1'b1;
        end
        tick();
        result_push = 1'b0; endop = 1'b0;
        tog = 1'b1;
        out_ready = (rmode == 2) ? 1'($urandom) : 1'b1;

        got_done = 0; prev_stall = 0; last_cyc = -1; cyc = 0; nx = 0; prev_data = 0;
        while (!got_done && cyc < 300) begin
            @(negedge clk);
            if (cyc == 0 && rmode == 0) check_val("first_valid", out_valid, exp_q.size() != 0);
            if (prev_stall) begin
                check_val("hold_valid", out_valid, 1);
                check_val("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                check_val("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check_val("byte", out_data, b);
                    if (exp_q.size() == 0) last_cyc = cyc;
                end
                nx++;
                if (abort_after > 0 && nx == abort_after) begin
                    #2 reset = 1'b0;
                    #1;
                    check_val("rst_valid", out_valid, 0);
                    check_val("rst_busy", busy, 0);
                    check_val("rst_done", done, 0);
                    check_val("rst_data", out_data, 0);
                    out_ready = 1'b0;
                    tick();
                    tick();
                    reset = 1'b1;
                    return;
                end
            end
            if (done) begin
                got_done = 1;
                check_val("done_valid_low", out_valid, 0);
                check_val("done_busy_low", busy, 0);
                if (last_cyc >= 0) check_val("done_timing", cyc, last_cyc + 1);
                else check_val("done_empty_timing", cyc <= 1, 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (!got_done) begin
                tick();
                tog = ~tog;
                out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom);
            end
            cyc++;
        end
        check_val("done_seen", got_done, 1);
        check_val("bytes_left", exp_q.size(), 0);
        check_val("overflow", overflow, n > cap);
        @(negedge clk);
        check_val("done_single", done, 0);
        check_val("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_valid", out_valid, 0);
        check_val("reset_data", out_data, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_ovf", overflow, 0);
        tick();
        reset = 1'b1;
        tick();

        // IDLE ignores endop/push
        endop = 1'b1; result_push = 1'b1;
        tick();
        endop = 1'b0; result_push = 1'b0;
        @(negedge clk);
        check_val("idle_ignore_busy", busy, 0);
        check_val("idle_ignore_done", done, 0);

        words = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};
        run_op(8'd4, 0, 0, 0, 0);
        run_op(8'd4, 0, 1, 0, 0);
        words = '{16'h0102, 16'h0304, 16'h0506};
        run_op(8'd2, 0, 0, 0, 0);
        words = '{16'h1111, 16'h2222, 16'h3333};
        run_op(8'd3, 1, 0, 0, 0);
        words.delete();
        run_op(8'd0, 0, 0, 0, 0);
        words.delete();
        for (int i = 0; i < 9; i++) words.push_back(DW'($urandom));
        run_op(8'd20, 0, 0, 0, 0);
        words = '{16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2};
        run_op(8'd4, 0, 0, 0, 3);
        run_op(8'd4, 0, 0, 0, 0);

        for (int t = 0; t < 25; t++) begin
            int np;
            words.delete();
            np = $urandom_range(0, 10);
            for (int i = 0; i < np; i++) words.push_back(DW'($urandom));
            run_op(8'($urandom_range(0, 11)), 1'($urandom), $urandom_range(0, 2), 1'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
